// File: rtl/sqrt_control.sv
// Control unit for an incremental square-root datapath.
// The datapath keeps square=(root+1)^2 and root, and reports N = square > operand.
// This unit accepts an operand, boots the datapath, then alternates CHECK and
// STEP until N rises. It then captures the root and pulses done_o.
// An iteration watchdog aborts with err_o if N never rises.
// Every output is a registered decode of the next state, so no output
// depends combinationally on N_i.

module sqrt_control #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_ITER   = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,        // active-high synchronous reset
    input  logic                      start_i,
    input  logic [DATA_WIDTH-1:0]     valor_i,
    output logic                      ready_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [DATA_WIDTH/2-1:0]   root_o,
    output logic [DATA_WIDTH-1:0]     valor_o,
    output logic                      boot_o,
    output logic                      wr_square_o,
    output logic                      wr_root_o,
    output logic                      muxes_o,
    input  logic                      N_i,
    input  logic [DATA_WIDTH/2-1:0]   root_i
);

    localparam int ROOT_W = DATA_WIDTH / 2;
    localparam int CNT_W  = $clog2(MAX_ITER + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BOOT  = 3'd1,
        S_CHECK = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] valor_q, valor_d;
    logic [ROOT_W-1:0]   root_q, root_d;
    logic                err_q, err_d;

    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                boot_q, boot_d;
    logic                wr_square_q, wr_square_d;
    logic                wr_root_q, wr_root_d;
    logic                muxes_q, muxes_d;

    // Next-state, datapath bookkeeping, and output decode of the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valor_d = valor_q;
        root_d  = root_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    valor_d = valor_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_BOOT;
                end
            end
            S_BOOT: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // N_i reflects the register writes made at the previous edge.
                if (N_i) begin
                    root_d  = root_i;
                    state_d = S_DONE;
                end else if (cnt_q == MAX_CNT) begin
                    err_d   = 1'b1;
                    root_d  = root_i;
                    state_d = S_DONE;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                // Saturate rather than wrap; CHECK stops the run at MAX_CNT anyway.
                if (cnt_q != MAX_CNT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d     = (state_d == S_IDLE);
        busy_d      = (state_d == S_BOOT) || (state_d == S_CHECK) || (state_d == S_STEP);
        done_d      = (state_d == S_DONE);
        boot_d      = (state_d == S_BOOT);
        wr_square_d = (state_d == S_BOOT) || (state_d == S_STEP);
        wr_root_d   = (state_d == S_BOOT) || (state_d == S_STEP);
        muxes_d     = (state_d == S_STEP);
    end

    // State, datapath-facing registers and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            valor_q     <= '0;
            root_q      <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            boot_q      <= 1'b0;
            wr_square_q <= 1'b0;
            wr_root_q   <= 1'b0;
            muxes_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valor_q     <= valor_d;
            root_q      <= root_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            boot_q      <= boot_d;
            wr_square_q <= wr_square_d;
            wr_root_q   <= wr_root_d;
            muxes_q     <= muxes_d;
        end
    end

    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign root_o      = root_q;
    assign valor_o     = valor_q;
    assign boot_o      = boot_q;
    assign wr_square_o = wr_square_q;
    assign wr_root_o   = wr_root_q;
    assign muxes_o     = muxes_q;

endmodule

// File: tb/tb_sqrt_control.sv
// Bench for sqrt_control, paired with a behavioural model of the square-root
// datapath: root register plus N = (root+1)^2 > operand.
`timescale 1ns/1ps

module tb_sqrt_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] valor_i = '0;
    logic        ready_o, busy_o, done_o, err_o;
    logic [7:0]  root_o;
    logic [15:0] valor_o;
    logic        boot_o, wr_square_o, wr_root_o, muxes_o;
    logic        N_i;
    logic [7:0]  root_i;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] prev_root = '0;

    logic        force_n0 = 1'b0;
    logic [7:0]  root_m = '0;
    logic [16:0] sq_m;

    always #5 clk = ~clk;

    sqrt_control #(.DATA_WIDTH(16), .MAX_ITER(256)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .valor_i(valor_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .root_o(root_o), .valor_o(valor_o), .boot_o(boot_o),
        .wr_square_o(wr_square_o), .wr_root_o(wr_root_o), .muxes_o(muxes_o),
        .N_i(N_i), .root_i(root_i)
    );

    // Datapath model: boot loads root=0 (square=1); a step increments root.
    always_ff @(posedge clk) begin
        if (boot_o)                      root_m <= 8'd0;
        else if (wr_root_o && muxes_o)   root_m <= root_m + 8'd1;
    end
    assign sq_m   = ({9'd0, root_m} + 17'd1) * ({9'd0, root_m} + 17'd1);
    assign N_i    = force_n0 ? 1'b0 : (sq_m > {1'b0, valor_o});
    assign root_i = root_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start one computation and follow it to done_o, checking latency and result.
    task automatic run_op(input logic [15:0] v, input logic hold, input logic [15:0] v_mid,
                          input logic [7:0] exp_root, input int exp_cyc, input logic exp_err);
        int   cyc;
        logic seen, bad_rdy, bad_val, bad_root;
        @(negedge clk);
        chk("ready_before_start", 32'(ready_o), 32'd1);
        start_i = 1'b1;
        valor_i = v;
        @(posedge clk); #1;
        cyc = 1;
        if (hold) valor_i = v_mid;
        else      start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("err_clear_on_start", 32'(err_o), 32'd0);
        seen = 1'b0; bad_rdy = 1'b0; bad_val = 1'b0; bad_root = 1'b0;
        while (!seen && cyc < 700) begin
            if (done_o) seen = 1'b1;
            else begin
                if (ready_o) bad_rdy = 1'b1;
                if (root_o != prev_root) bad_root = 1'b1;
            end
            if (valor_o != v) bad_val = 1'b1;
            if (!seen) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_cycle", 32'(cyc), 32'(exp_cyc));
        chk("root_result", 32'(root_o), 32'(exp_root));
        chk("err_result", 32'(err_o), 32'(exp_err));
        chk("ready_low_during_run", 32'(bad_rdy), 32'd0);
        chk("valor_o_held", 32'(bad_val), 32'd0);
        chk("root_o_held_prev", 32'(bad_root), 32'd0);
        prev_root = exp_root;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("ready_after_done", 32'(ready_o), 32'd1);
        chk("idle_not_busy", 32'(busy_o), 32'd0);
        chk("root_kept", 32'(root_o), 32'(exp_root));
    endtask

    typedef struct {
        logic [15:0] valor;
        logic [7:0]  root;
        int          cyc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int   cyc;
        logic seen, bad;

        tbl[0] = '{16'd0,     8'd0,   3};
        tbl[1] = '{16'd16,    8'd4,   11};
        tbl[2] = '{16'd15,    8'd3,   9};
        tbl[3] = '{16'd1,     8'd1,   5};
        tbl[4] = '{16'd3,     8'd1,   5};
        tbl[5] = '{16'd4,     8'd2,   7};
        tbl[6] = '{16'd100,   8'd10,  23};
        tbl[7] = '{16'd99,    8'd9,   21};
        tbl[8] = '{16'd65535, 8'd255, 513};

        // Reset state
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_root", 32'(root_o), 32'd0);
        chk("rst_valor", 32'(valor_o), 32'd0);
        chk("rst_ctrl", 32'({boot_o, wr_square_o, wr_root_o, muxes_o}), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;

        // Table of operands, run back to back
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].valor, 1'b0, 16'd0, tbl[i].root, tbl[i].cyc, 1'b0);
        end

        // Handshake: start held high throughout, operand changes mid-run
        run_op(16'd16, 1'b1, 16'd200, 8'd4, 11, 1'b0);
        // start still high: DUT is in IDLE now and accepts on this edge
        valor_i = 16'd9;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("hs_second_accept", 32'(busy_o), 32'd1);
        chk("hs_second_valor", 32'(valor_o), 32'd9);
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 700) begin
            if (done_o) seen = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        chk("hs_second_done", 32'(seen), 32'd1);
        chk("hs_second_cycle", 32'(cyc), 32'd9);
        chk("hs_second_root", 32'(root_o), 32'd3);
        prev_root = 8'd3;
        @(posedge clk); #1;

        // Reset in the middle of a run
        @(negedge clk);
        start_i = 1'b1;
        valor_i = 16'd1000;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (!muxes_o && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midrun_step_seen", 32'(muxes_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        chk("midrst_root", 32'(root_o), 32'd0);
        chk("midrst_valor", 32'(valor_o), 32'd0);
        chk("midrst_ctrl", 32'({boot_o, wr_square_o, wr_root_o, muxes_o}), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_o || busy_o) bad = 1'b1;
        end
        chk("midrst_no_done", 32'(bad), 32'd0);
        prev_root = 8'd0;
        run_op(16'd9, 1'b0, 16'd0, 8'd3, 9, 1'b0);

        // Watchdog: N held low, abort after 256 steps (root model wraps to 0)
        force_n0 = 1'b1;
        run_op(16'd50, 1'b0, 16'd0, 8'd0, 3 + 2 * 256, 1'b1);
        force_n0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky_idle", 32'(err_o), 32'd1);
        run_op(16'd4, 1'b0, 16'd0, 8'd2, 7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d, expected %0d", 0, 1);
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/sqrt_control.md
Name: sqrt_control

Overview:
- Control unit for the incremental square-root datapath: square register starts at 1, root register starts at 0, both step until the N flag reports square > operand.
- Sits directly upstream of the datapath. Accepts a 16-bit operand through a start/ready handshake, latches it, and sequences boot, wr_square, wr_root and muxes.
- Watches the datapath N flag, captures the final root and signals done.
- Includes an iteration watchdog so a stuck flag cannot hang the unit.

Parameters:
- DATA_WIDTH, 16, operand width. Root width is DATA_WIDTH/2.
- MAX_ITER, 256, number of STEP cycles allowed before the watchdog aborts with err_o.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; synchronous, active-high (asserted = 1) despite the name.
- start_i  input  1  request. Sampled only when ready_o=1.
- valor_i  input  16  operand. Sampled with start_i.
- ready_o  output  1  high in IDLE only.
- busy_o  output  1  high in BOOT, CHECK and STEP.
- done_o  output  1  one-cycle pulse when a result is valid.
- err_o  output  1  set together with done_o when the watchdog fires; cleared on the next accepted start.
- root_o  output  8  captured result. Held until the next done_o.
- valor_o  output  16  latched operand driven to the datapath.
- boot_o  output  1  datapath boot: loads SQUARE_INIT=1 and ROOT_INIT=0.
- wr_square_o  output  1  square register write enable.
- wr_root_o  output  1  root register write enable.
- muxes_o  output  1  high during STEP; selects the incremented/added values.
- N_i  input  1  datapath flag: square > valor_o.
- root_i  input  8  datapath root register value.

Behaviour:
- Reset (rst_n=1 at a clock edge) forces:
  - state = IDLE, ready_o=1
  - busy_o, done_o, err_o = 0
  - root_o=0, valor_o=0
  - boot_o, wr_square_o, wr_root_o, muxes_o = 0
  - iteration counter = 0
- Reset mid-operation abandons the computation; no done_o is produced.
- All control outputs are registered-state decodes (Moore). There is no combinational path from N_i to any output.
- IDLE:
  - ready_o=1.
  - start_i=1 latches valor_i into valor_o, clears err_o and the counter, then moves to BOOT.
  - start_i=0 stays in IDLE.
- BOOT: boot_o=1, wr_square_o=1, wr_root_o=1. Next state is CHECK.
- CHECK:
  - Control outputs are 0. N_i is valid because the registers were updated at the previous edge.
  - N_i=1: root_o <= root_i, then DONE.
  - N_i=0 and counter == MAX_ITER: err_o <= 1, root_o <= root_i, then DONE.
  - Otherwise: go to STEP.
- STEP: muxes_o=1, wr_square_o=1, wr_root_o=1, counter increments. Next state is CHECK.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i is ignored in every state other than IDLE, including DONE.
- Latency: start accepted at edge 0 puts done_o high in cycle 3+2·R, where R is the final root. Examples: R=0 gives cycle 3; R=255 gives cycle 513.
- Counter width is ceil(log2(MAX_ITER+1)). It never wraps; the comparison to MAX_ITER stops it.
- With a correct datapath, valor=65535 needs 255 STEPs, so err_o never fires.
- valor_o and root_o are stable outside their update edges. root_o keeps the previous result during a new computation.

Test Plan:
The bench pairs the DUT with a behavioural datapath model: square=(root+1)², N = square > valor.
- Operand 0: start with valor_i=0 → no STEP, done_o in cycle 3, root_o=0, err_o=0.
- Operand 16 and operand 15:
  - valor_i=16 → done_o in cycle 11, root_o=4.
  - Back-to-back valor_i=15 → root_o=3; root_o holds 4 until that done.
- Maximum operand: valor_i=65535 → root_o=255, done_o in cycle 513, err_o=0; ready_o low throughout.
- Handshake: start_i held high across the whole computation and into the DONE cycle → exactly one computation; the next start is accepted only in the IDLE cycle after DONE; valor_i changes mid-run do not alter valor_o.
- Reset mid-run: rst_n=1 during STEP of valor_i=1000 → next cycle all outputs at reset values and ready_o=1; a following run with valor_i=9 gives root_o=3.
- Watchdog: force N_i=0 → done_o with err_o=1 after MAX_ITER STEPs (cycle 3+2·256); err_o clears on the next start.
